// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
// Deserializes the codec ADC stream into parallel stereo samples. bclk, adclrc
// and adcdat are oversampled in the clock_50M domain. A complete left slot
// followed by a complete right slot produces one sample_valid pulse. A slot
// that is cut short produces one frame_err pulse.
//
// state | meaning
// IDLE  | after reset, waiting for the first adclrc transition
// SKIP  | discarding the one-bclk I2S delay at the start of a slot
// SHIFT | capturing data bits MSB first
// HOLD  | slot complete, ignoring surplus bclk until the next adclrc edge
`timescale 1ns/1ps
module i2s_adc_receiver #(
    parameter int DATA_WIDTH = 16,
    parameter int I2S_DELAY  = 1,
    parameter bit LEFT_LEVEL = 1'b0
) (
    input  logic                  clock_50M,
    input  logic                  rst_n,
    input  logic                  bclk,
    input  logic                  adclrc,
    input  logic                  adcdat,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  frame_err
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // synchronizer and edge-detect flops
    logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic r_lrc_s1, r_lrc_s2, r_lrc_s3;
    logic r_dat_s1, r_dat_s2;
    logic [1:0] r_prime_cnt;

    // slot capture
    state_t                r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_is_left;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  r_left_ok;

    // outputs
    logic [DATA_WIDTH-1:0] r_left_data;
    logic [DATA_WIDTH-1:0] r_right_data;
    logic                  r_sample_valid;
    logic                  r_frame_err;

    logic                  w_armed;
    logic                  w_bclk_rise;
    logic                  w_lrc_edge;
    logic [DATA_WIDTH-1:0] w_shift_word;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_shreg_nxt;
    logic                  w_is_left_nxt;
    logic                  w_complete;
    logic                  w_err;
    logic                  w_restart;
    logic                  w_new_bit;

    // The edge-detect flop resets to 0, so a high adclrc at reset release would
    // look like a transition. Edges are ignored until the pipeline has filled.
    assign w_armed      = (r_prime_cnt == 2'd3);
    assign w_bclk_rise  = r_bclk_s2 & ~r_bclk_s3;
    assign w_lrc_edge   = w_armed & (r_lrc_s2 != r_lrc_s3);
    assign w_shift_word = {r_shreg[DATA_WIDTH-2:0], r_dat_s2};

    // Two-flop synchronizers; third stage on bclk/adclrc for edge detect.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk_s1 <= 1'b0;
            r_bclk_s2 <= 1'b0;
            r_bclk_s3 <= 1'b0;
            r_lrc_s1  <= 1'b0;
            r_lrc_s2  <= 1'b0;
            r_lrc_s3  <= 1'b0;
            r_dat_s1  <= 1'b0;
            r_dat_s2  <= 1'b0;
        end else begin
            r_bclk_s1 <= bclk;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_s3 <= r_bclk_s2;
            r_lrc_s1  <= adclrc;
            r_lrc_s2  <= r_lrc_s1;
            r_lrc_s3  <= r_lrc_s2;
            r_dat_s1  <= adcdat;
            r_dat_s2  <= r_dat_s1;
        end
    end

    // Count the cycles needed to fill the synchronizer after reset.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_prime_cnt <= 2'd0;
        end else if (!w_armed) begin
            r_prime_cnt <= r_prime_cnt + 2'd1;
        end
    end

    // Slot FSM state and capture registers.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_is_left <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_is_left <= w_is_left_nxt;
        end
    end

    // Next-state logic. An adclrc edge wins over a same-cycle bclk rise, which
    // then belongs to the new slot, except when that rise carries the last bit
    // of the current slot: the slot completes and the rise is consumed by it.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_is_left_nxt = r_is_left;
        w_complete    = 1'b0;
        w_err         = 1'b0;
        w_restart     = 1'b0;
        w_new_bit     = w_bclk_rise;

        case (r_state)
            S_IDLE: begin
                w_restart = w_lrc_edge;
            end
            S_SKIP: begin
                if (w_lrc_edge) begin
                    w_restart = 1'b1;
                    w_err     = 1'b1;
                end else if (w_bclk_rise) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_bclk_rise) begin
                    w_shreg_nxt = w_shift_word;
                    w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_BIT) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
                if (w_lrc_edge) begin
                    w_restart = 1'b1;
                    if (w_bclk_rise && (r_bit_cnt == LAST_BIT)) begin
                        w_new_bit = 1'b0;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                w_restart = w_lrc_edge;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_restart) begin
            w_is_left_nxt = (r_lrc_s2 == LEFT_LEVEL);
            w_shreg_nxt   = '0;
            w_cnt_nxt     = '0;
            if (I2S_DELAY != 0) begin
                w_state_nxt = w_new_bit ? S_SHIFT : S_SKIP;
            end else begin
                w_state_nxt = S_SHIFT;
                if (w_new_bit) begin
                    w_shreg_nxt = {{(DATA_WIDTH-1){1'b0}}, r_dat_s2};
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
        end
    end

    // Pair completed slots into stereo samples and drive the pulse outputs.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_left_hold    <= '0;
            r_left_ok      <= 1'b0;
            r_left_data    <= '0;
            r_right_data   <= '0;
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_err    <= w_err;
            if (w_complete) begin
                if (r_is_left) begin
                    r_left_hold <= w_shift_word;
                    r_left_ok   <= 1'b1;
                end else if (r_left_ok) begin
                    r_left_data    <= r_left_hold;
                    r_right_data   <= w_shift_word;
                    r_sample_valid <= 1'b1;
                    r_left_ok      <= 1'b0;
                end
            end else if (w_err && r_is_left) begin
                r_left_ok <= 1'b0;
            end
        end
    end

    assign left_data    = r_left_data;
    assign right_data   = r_right_data;
    assign sample_valid = r_sample_valid;
    assign frame_err    = r_frame_err;

endmodule

// File: doc/i2s_adc_receiver.md
# i2s_adc_receiver

Receive-side counterpart of the DAC serializer in the audio path. Deserializes the codec ADC stream (adcdat), framed by an externally generated bit clock (bclk) and left/right clock (adclrc), into parallel 16-bit stereo samples. All codec inputs are oversampled in the clock_50M domain. One-cycle sample_valid per stereo frame feeds the capture RAM/FIFO writer.

## Interface
- DATA_WIDTH, 16: bits captured per channel slot, MSB first.
- I2S_DELAY, 1: bclk rising edges skipped after each adclrc transition before the MSB (1 = Philips I2S, 0 = left-justified).
- LEFT_LEVEL, 0: adclrc level that marks the left slot.

- clock_50M  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bclk  input  1  codec bit clock, asynchronous to clock_50M.
- adclrc  input  1  codec ADC frame clock, asynchronous.
- adcdat  input  1  codec serial data, changes on bclk falling edge.
- left_data  output  DATA_WIDTH  last complete left sample.
- right_data  output  DATA_WIDTH  last complete right sample.
- sample_valid  output  1  one-cycle pulse: left_data/right_data updated.
- frame_err  output  1  one-cycle pulse: slot ended with fewer than DATA_WIDTH bits.

## Operation
- Synchronizers: bclk, adclrc and adcdat each pass through two flops (s1, s2). A third flop on bclk and adclrc gives edge detect. bclk_rise = s2 & ~s3. lrc_edge = s2 != s3. adcdat uses the same depth so data stays aligned with bclk_rise.
- Channel of a slot = synchronized adclrc level after lrc_edge (== LEFT_LEVEL → left).
- FSM states:
  - IDLE: after reset; ignores all bits until the first lrc_edge → SKIP (I2S_DELAY=1) or SHIFT (I2S_DELAY=0).
  - SKIP: the next bclk_rise is discarded → SHIFT.
  - SHIFT: each bclk_rise shifts adcdat into shreg LSB (shift left) and increments bit_cnt. When bit_cnt reaches DATA_WIDTH → complete slot → HOLD.
  - HOLD: extra bclk_rise ignored (slots of 32 bclk accepted) until lrc_edge.
- lrc_edge from SKIP, SHIFT or HOLD restarts the slot: bit_cnt←0, state per I2S_DELAY. If it arrives in SKIP/SHIFT with bit_cnt < DATA_WIDTH, frame_err pulses and the partial word is discarded.
- Complete left slot: left_hold←word, left_ok←1.
- Complete right slot with left_ok=1: left_data←left_hold, right_data←word, sample_valid pulse, left_ok←0. With left_ok=0 (right slot first after reset, or left slot errored): word dropped, no pulse, no error.
- Simultaneous lrc_edge and bclk_rise in one cycle: the edge is processed first. The bclk_rise then belongs to the new slot (skip bit if I2S_DELAY=1, MSB if 0).
- The completing bit and a same-cycle lrc_edge: the slot completes (count includes that bit), then restarts. No error.

## Timing
- Reset (async assert, sync-safe deassert assumed upstream): state=IDLE, bit_cnt=0, shreg=0, left_hold=0, left_ok=0, all synchronizer flops=0, left_data=0, right_data=0, sample_valid=0, frame_err=0.
- Reset mid-frame: everything is discarded and the block waits in IDLE for a fresh lrc_edge.
- bclk high and low phases must each be ≥3 clock_50M periods (bclk ≤ 8 MHz). Faster bclk is unsupported.
- Latency: sample_valid asserts at the 3rd clock_50M rising edge after the pin-level bclk rise that carries the last right bit. It may land on the 4th edge depending on sampling phase. Data outputs are valid in the same cycle and held until the next pulse.
- sample_valid and frame_err are exactly 1 cycle wide. They never assert in the same cycle.

## Test plan
- Reset: hold rst_n=0 with bclk/adclrc toggling → all outputs 0. Release mid-right-slot → no sample_valid until a full left+right frame follows.
- I2S_DELAY=1, 32 bclk/slot, bclk=50M/16: left 0xA55A, right 0x1234 → one sample_valid, left_data=0xA55A, right_data=0x1234, frame_err=0. Three back-to-back frames → three pulses, one per frame.
- I2S_DELAY=0, 16 bclk/slot: left 0xFFFF, right 0x0001 → left_data=0xFFFF, right_data=0x0001.
- Short slot: left slot truncated to 10 bits → frame_err pulse at the edge, the following right 0x00FF gives no sample_valid. The next full frame (0x1111/0x2222) outputs normally.
- Simultaneous edges: force lrc_edge and bclk_rise in the same clock_50M cycle (I2S_DELAY=0). Frame 0x8001/0x7FFE → captured exactly, MSB taken on that cycle.
- Async reset asserted mid-SHIFT → outputs 0 immediately. After release, a first right-only slot is dropped silently (no pulse, no error).
